fifo_ptr_ctrl: RTL and testbench

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

---
 rtl/fifo_ptr_ctrl.sv | 134 +++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: write/read grant, wrap-bit pointers, occupancy and flush sequencing
// for an external power-of-two FIFO storage array.
module fifo_ptr_ctrl #(
   parameter int OSTD_NUM = 8,
   parameter int PTR_SIZE = $clog2(OSTD_NUM)
) (
   input  logic                clk_in,
   input  logic                areset_b,
   input  logic                trans_write,
   input  logic                trans_read,
   input  logic                flush_req,
   output logic                fifo_wenable,
   output logic                fifo_renable,
   output logic [PTR_SIZE:0]   write_ptr,
   output logic [PTR_SIZE:0]   read_ptr,
   output logic [PTR_SIZE:0]   occupancy,
   output logic                full,
   output logic                empty,
   output logic                rd_valid,
   output logic                flush_done
);

   localparam logic [0:0]        ST_RUN   = 1'b0;
   localparam logic [0:0]        ST_FLUSH = 1'b1;
   localparam logic [PTR_SIZE:0] PTR_ONE  = (PTR_SIZE+1)'(1);

   logic [0:0]        state_q, state_d;
   logic [PTR_SIZE:0] wptr_q, wptr_d;
   logic [PTR_SIZE:0] rptr_q, rptr_d;
   logic [PTR_SIZE:0] occ_q, occ_d;
   logic              rd_valid_q;
   logic              flush_done_q, flush_done_d;
   logic              wen_s, ren_s;
   logic              full_s, empty_s;

   assign full_s  = (wptr_q[PTR_SIZE-1:0] == rptr_q[PTR_SIZE-1:0]) &&
                    (wptr_q[PTR_SIZE] != rptr_q[PTR_SIZE]);
   assign empty_s = (wptr_q == rptr_q);

   // Grant decode; the write grant is masked by reset because full is low while reset holds.
   always_comb begin
      ren_s = 1'b0;
      wen_s = 1'b0;
      case (state_q)
         ST_RUN: begin
            ren_s = trans_read && !empty_s;
            wen_s = areset_b && trans_write && (!full_s || ren_s);
         end
         ST_FLUSH: begin
            ren_s = !empty_s;
            wen_s = 1'b0;
         end
         default: begin
            ren_s = 1'b0;
            wen_s = 1'b0;
         end
      endcase
   end

   // Next-state for pointers, occupancy and the RUN/FLUSH sequencer.
   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      occ_d        = occ_q;
      state_d      = state_q;
      flush_done_d = 1'b0;
      if (wen_s) begin
         wptr_d = wptr_q + PTR_ONE;
      end else begin
         wptr_d = wptr_q;
      end
      if (ren_s) begin
         rptr_d = rptr_q + PTR_ONE;
      end else begin
         rptr_d = rptr_q;
      end
      case ({wen_s, ren_s})
         2'b10:   occ_d = occ_q + PTR_ONE;
         2'b01:   occ_d = occ_q - PTR_ONE;
         default: occ_d = occ_q;
      endcase
      case (state_q)
         ST_RUN: begin
            if (flush_req) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // Occupancy of one here means the last entry is being read this cycle.
            if (occ_q <= PTR_ONE) begin
               state_d      = ST_RUN;
               flush_done_d = 1'b1;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk_in or negedge areset_b) begin
      if (!areset_b) begin
         state_q      <= ST_RUN;
         wptr_q       <= '0;
         rptr_q       <= '0;
         occ_q        <= '0;
         rd_valid_q   <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         occ_q        <= occ_d;
         rd_valid_q   <= ren_s;
         flush_done_q <= flush_done_d;
      end
   end

   assign fifo_wenable = wen_s;
   assign fifo_renable = ren_s;
   assign write_ptr    = wptr_q;
   assign read_ptr     = rptr_q;
   assign occupancy    = occ_q;
   assign full         = full_s;
   assign empty        = empty_s;
   assign rd_valid     = rd_valid_q;
   assign flush_done   = flush_done_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: queue-based reference model checked every falling edge,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_ptr_ctrl;

   localparam int DEPTH = 8;

   logic       clk_in = 1'b0;
   logic       areset_b;
   logic       trans_write, trans_read, flush_req;
   logic       fifo_wenable, fifo_renable;
   logic [3:0] write_ptr, read_ptr, occupancy;
   logic       full, empty, rd_valid, flush_done;

   int n_checks = 0;
   int n_err    = 0;
   int ren_cnt  = 0;
   int rdv_cnt  = 0;

   // Reference model: stored entries as a queue, pointers as running counts.
   int q[$];
   int wcnt      = 0;
   int rcnt      = 0;
   bit flushing  = 1'b0;
   bit m_rdv     = 1'b0;
   bit m_done    = 1'b0;

   fifo_ptr_ctrl #(.OSTD_NUM(DEPTH)) dut (
      .clk_in       (clk_in),
      .areset_b     (areset_b),
      .trans_write  (trans_write),
      .trans_read   (trans_read),
      .flush_req    (flush_req),
      .fifo_wenable (fifo_wenable),
      .fifo_renable (fifo_renable),
      .write_ptr    (write_ptr),
      .read_ptr     (read_ptr),
      .occupancy    (occupancy),
      .full         (full),
      .empty        (empty),
      .rd_valid     (rd_valid),
      .flush_done   (flush_done)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_ren();
      if (!areset_b) return 1'b0;
      if (flushing) return q.size() > 0;
      return trans_read && (q.size() > 0);
   endfunction

   function automatic bit m_wen();
      if (!areset_b || flushing) return 1'b0;
      return trans_write && ((q.size() < DEPTH) || m_ren());
   endfunction

   always @(negedge areset_b) begin
      q.delete();
      wcnt     = 0;
      rcnt     = 0;
      flushing = 1'b0;
      m_rdv    = 1'b0;
      m_done   = 1'b0;
   end

   // Compare DUT to model, then advance the model for the coming rising edge.
   always @(negedge clk_in) begin : cmp
      bit r_e, w_e;
      r_e = m_ren();
      w_e = m_wen();
      chk("wenable", fifo_wenable, w_e);
      chk("renable", fifo_renable, r_e);
      chk("write_ptr", write_ptr, wcnt % 16);
      chk("read_ptr", read_ptr, rcnt % 16);
      chk("occupancy", occupancy, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("rd_valid", rd_valid, m_rdv);
      chk("flush_done", flush_done, m_done);
      chk("occ_vs_ptrs", occupancy, 4'(write_ptr - read_ptr));
      if (fifo_renable) ren_cnt++;
      if (rd_valid) rdv_cnt++;
      if (areset_b) begin
         if (r_e) begin
            void'(q.pop_front());
            rcnt++;
         end
         if (w_e) begin
            q.push_back(wcnt);
            wcnt++;
         end
         m_rdv = r_e;
         if (flushing) begin
            if (q.size() == 0) begin
               flushing = 1'b0;
               m_done   = 1'b1;
            end else begin
               m_done = 1'b0;
            end
         end else begin
            m_done = 1'b0;
            if (flush_req) flushing = 1'b1;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      int ren_base, rdv_base;
      areset_b = 1'b0; trans_write = 1'b1; trans_read = 1'b0; flush_req = 1'b0;
      #2;
      chk("rst_wen", fifo_wenable, 0);
      chk("rst_ren", fifo_renable, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_wptr", write_ptr, 0);
      chk("rst_flush_done", flush_done, 0);
      #6 areset_b = 1'b1;

      // Fill: first edge after release already writes.
      next_cycle();
      chk("first_edge_wptr", write_ptr, 1);
      repeat (7) next_cycle();
      chk("fill_wptr", write_ptr, 4'b1000);
      chk("fill_occ", occupancy, 8);
      chk("fill_full", full, 1);
      chk("ninth_wen", fifo_wenable, 0);
      next_cycle();
      chk("ninth_wptr", write_ptr, 4'b1000);

      // Simultaneous read and write while full.
      trans_read = 1'b1;
      #1;
      chk("full_rw_wen", fifo_wenable, 1);
      chk("full_rw_ren", fifo_renable, 1);
      next_cycle();
      chk("full_rw_occ", occupancy, 8);
      chk("full_rw_wptr", write_ptr, 4'b1001);
      chk("full_rw_rptr", read_ptr, 4'b0001);

      // Drain, then simultaneous requests on empty.
      trans_write = 1'b0;
      repeat (8) next_cycle();
      chk("drain_empty", empty, 1);
      trans_write = 1'b1;
      #1;
      chk("empty_rw_wen", fifo_wenable, 1);
      chk("empty_rw_ren", fifo_renable, 0);
      next_cycle();
      chk("empty_rw_occ", occupancy, 1);

      // Wrap-around from a fresh reset.
      areset_b = 1'b0; trans_write = 1'b0; trans_read = 1'b0;
      next_cycle();
      areset_b = 1'b1;
      ren_base = ren_cnt;
      rdv_base = rdv_cnt;
      for (int i = 0; i < 12; i++) begin
         trans_write = 1'b1; trans_read = 1'b0;
         next_cycle();
         trans_write = 1'b0; trans_read = 1'b1;
         next_cycle();
      end
      trans_read = 1'b0;
      chk("wrap_wptr", write_ptr, 4'b1100);
      chk("wrap_rptr", read_ptr, 4'b1100);
      chk("wrap_empty", empty, 1);
      next_cycle();
      chk("wrap_ren_count", ren_cnt - ren_base, 12);
      chk("wrap_rdv_count", rdv_cnt - rdv_base, 12);

      // Flush with five entries while writes keep being requested.
      trans_write = 1'b1;
      repeat (5) next_cycle();
      trans_write = 1'b0; flush_req = 1'b1;
      #1;
      chk("flush_start_occ", occupancy, 5);
      next_cycle();
      flush_req = 1'b0; trans_write = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("flush_ren", fifo_renable, 1);
         chk("flush_wen", fifo_wenable, 0);
         chk("flush_done_early", flush_done, 0);
         next_cycle();
      end
      trans_write = 1'b0;
      #1;
      chk("flush_done_pulse", flush_done, 1);
      chk("flush_occ", occupancy, 0);
      chk("flush_wptr", write_ptr, 4'b0001);
      next_cycle();
      chk("flush_done_one_cycle", flush_done, 0);

      // Flush while empty.
      flush_req = 1'b1;
      next_cycle();
      flush_req = 1'b0;
      #1;
      chk("eflush_c1", flush_done, 0);
      next_cycle();
      chk("eflush_c2", flush_done, 1);
      chk("eflush_wptr", write_ptr, 4'b0001);
      chk("eflush_rptr", read_ptr, 4'b0001);
      next_cycle();
      chk("eflush_c3", flush_done, 0);

      // Reset during the third flush cycle.
      trans_write = 1'b1;
      repeat (5) next_cycle();
      trans_write = 1'b0; flush_req = 1'b1;
      next_cycle();
      flush_req = 1'b0;
      next_cycle();
      next_cycle();
      #1 areset_b = 1'b0;
      #1;
      chk("mid_rst_wptr", write_ptr, 0);
      chk("mid_rst_rptr", read_ptr, 0);
      chk("mid_rst_occ", occupancy, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_ren", fifo_renable, 0);
      chk("mid_rst_rdv", rd_valid, 0);
      next_cycle();
      areset_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         chk("no_done_after_rst", flush_done, 0);
      end

      // Mixed traffic with occasional flush requests, checked by the model.
      for (int i = 0; i < 300; i++) begin
         trans_write = 1'($urandom_range(0, 1));
         trans_read  = 1'($urandom_range(0, 1));
         flush_req   = ($urandom_range(0, 15) == 0);
         next_cycle();
      end
      trans_write = 1'b0; trans_read = 1'b0; flush_req = 1'b0;
      repeat (12) next_cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
